// File: rtl/bfly_reorder.sv
// Output reorder buffer for the 32-point IFFT: accepts bit-reversed butterfly pairs
// and streams each 32-sample frame out in natural order through ping-pong banks.
module bfly_reorder #(
    parameter int DW = 36
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] di1r,
    input  logic [DW-1:0] di1i,
    input  logic [DW-1:0] di2r,
    input  logic [DW-1:0] di2i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dor,
    output logic [DW-1:0] doi,
    output logic [4:0]    out_idx,
    output logic          out_last
);
    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    logic [2*DW-1:0] mem_q [64];
    logic [1:0]      full_q, full_d;
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [4:0]      rcnt_q, rcnt_d;
    state_t          state_q, state_d;
    logic [DW-1:0]   dor_q, dor_d;
    logic [DW-1:0]   doi_q, doi_d;
    logic            wr_en;
    logic [3:0]      wr_slot;
    logic            rd_en;
    logic [5:0]      rd_addr;
    logic [2*DW-1:0] rd_word;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    assign in_ready  = !full_q[wbank_q];
    assign wr_en     = in_valid && in_ready;
    assign wr_slot   = bitrev4(wcnt_q);
    assign rd_word   = mem_q[rd_addr];
    assign out_valid = (state_q == ST_SEND);
    assign out_idx   = rcnt_q;
    assign out_last  = out_valid && (rcnt_q == 5'd31);
    assign dor       = dor_q;
    assign doi       = doi_q;

    // Upper output lands at bitrev4(k), lower at bitrev4(k)+16 of the write bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wbank_q, 1'b0, wr_slot}] <= {di1r, di1i};
            mem_q[{wbank_q, 1'b1, wr_slot}] <= {di2r, di2i};
        end
    end

    always_comb begin
        full_d  = full_q;
        wbank_d = wbank_q;
        wcnt_d  = wcnt_q;
        rbank_d = rbank_q;
        rcnt_d  = rcnt_q;
        state_d = state_q;
        rd_en   = 1'b0;
        rd_addr = {rbank_q, rcnt_q};

        if (wr_en) begin
            wcnt_d = wcnt_q + 4'd1;
            if (wcnt_q == 4'd15) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (full_q[rbank_q]) begin
                    state_d = ST_SEND;
                    rcnt_d  = 5'd0;
                    rd_en   = 1'b1;
                    rd_addr = {rbank_q, 5'd0};
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (rcnt_q != 5'd31) begin
                        rcnt_d  = rcnt_q + 5'd1;
                        rd_en   = 1'b1;
                        rd_addr = {rbank_q, rcnt_q + 5'd1};
                    end else begin
                        // Release the drained bank; chain straight into the other if ready.
                        full_d[rbank_q] = 1'b0;
                        rbank_d         = ~rbank_q;
                        rcnt_d          = 5'd0;
                        if (full_q[~rbank_q]) begin
                            rd_en   = 1'b1;
                            rd_addr = {~rbank_q, 5'd0};
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dor_d = dor_q;
        doi_d = doi_q;
        if (rd_en) begin
            dor_d = rd_word[2*DW-1:DW];
            doi_d = rd_word[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            state_q <= ST_IDLE;
            dor_q   <= '0;
            doi_q   <= '0;
        end else begin
            full_q  <= full_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
            dor_q   <= dor_d;
            doi_q   <= doi_d;
        end
    end
endmodule
